// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment helpers for the BCD stopwatch core.
// Segment patterns are active-high {g,f,e,d,c,b,a}; the scan driver inverts them.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      SW_IDLE   = 2'd0,
      SW_RUN    = 2'd1,
      SW_PAUSED = 2'd2
   } sw_state_t;

   localparam logic [6:0] SEG_BLANK   = 7'b0000000;
   localparam logic [6:0] SEG_ILLEGAL = 7'b1000000;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'b0111111;
         4'd1:    pat = 7'b0000110;
         4'd2:    pat = 7'b1011011;
         4'd3:    pat = 7'b1001111;
         4'd4:    pat = 7'b1100110;
         4'd5:    pat = 7'b1101101;
         4'd6:    pat = 7'b1111101;
         4'd7:    pat = 7'b0000111;
         4'd8:    pat = 7'b1111111;
         4'd9:    pat = 7'b1101111;
         default: pat = SEG_ILLEGAL;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/sw_seg_scan.sv
// Multiplexed active-low 7-segment scan driver with a free-running prescaler.
// Leading-zero blanking is enabled by defining STOPWATCH_BLANK_LEADING_EN.
module sw_seg_scan
   import stopwatch_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV_W = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   shown,
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     dig_n
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCAN_DIV_W-1:0] pre;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_next;
   logic                  scan_tc;
   logic [3:0]            cur_digit;
   logic [6:0]            seg_pat;
   logic [DIGITS-1:0]     onehot;
   logic                  blank;

   assign scan_tc  = &pre;
   assign idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

   always_comb begin
      cur_digit = 4'd0;
      onehot    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_digit = shown[4*i +: 4];
            onehot[i] = 1'b1;
         end
      end
   end

`ifdef STOPWATCH_BLANK_LEADING_EN
   logic [IDX_W-1:0] top_nz;

   // Highest non-zero digit; digit 0 is the floor so a zero value still shows "0".
   always_comb begin
      top_nz = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (shown[4*i +: 4] != 4'd0) top_nz = IDX_W'(i);
      end
   end

   assign blank = (idx > top_nz);
`else
   assign blank = 1'b0;
`endif

   assign seg_pat = blank ? SEG_BLANK : seg_decode(cur_digit);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre   <= '0;
         idx   <= '0;
         seg_n <= '1;
         dig_n <= '1;
      end else begin
         pre <= pre + 1'b1;
         if (scan_tc) begin
            idx   <= idx_next;
            seg_n <= ~seg_pat;
            dig_n <= ~onehot;
         end
      end
   end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch: button sync/edge detect, run/pause FSM, tick divider,
// BCD count with sticky overflow, lap hold, and scan driver (STOPWATCH_BLANK_LEADING_EN in sw_seg_scan).
module bcd_stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int TICK_DIV       = 1200000,
   parameter int LAP_HOLD_TICKS = 20,
   parameter int SCAN_DIV_W     = 10
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  btn_start,
   input  logic                  btn_stop,
   input  logic                  btn_clear,
   input  logic                  btn_lap,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [4*DIGITS-1:0]   shown_bcd,
   output logic                  running,
   output logic                  lap_active,
   output logic                  overflow,
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     dig_n
);

   localparam int              DIV_W     = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [7:0]       HOLD_INIT = 8'(LAP_HOLD_TICKS);

   // Button order in the sync vectors: {lap, clear, stop, start}
   logic [3:0] btn_raw, sync_a, sync_b, sync_d, cmd;
   logic       cmd_start, cmd_stop, cmd_clear, cmd_lap;

   sw_state_t             state_q, state_d;
   logic [DIV_W-1:0]      div_q;
   logic                  tick;
   logic [4*DIGITS-1:0]   count_q, count_inc, lap_q;
   logic                  wrap;
   logic [7:0]            hold_q;
   logic                  ovf_q;

   assign btn_raw = {btn_lap, btn_clear, btn_stop, btn_start};

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_a <= '0;
         sync_b <= '0;
         sync_d <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         sync_d <= sync_b;
      end
   end

   assign cmd       = sync_b & ~sync_d;
   assign cmd_start = cmd[0];
   assign cmd_stop  = cmd[1];
   assign cmd_clear = cmd[2];
   assign cmd_lap   = cmd[3];

   always_ff @(posedge CLK) begin
      if (RST) state_q <= SW_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cmd_clear) begin
         state_d = SW_IDLE;
      end else if (cmd_stop) begin
         if (state_q == SW_RUN) state_d = SW_PAUSED;
      end else if (cmd_start) begin
         state_d = SW_RUN;
      end
   end

   assign tick = (state_q == SW_RUN) && (div_q == DIV_LAST);

   always_ff @(posedge CLK) begin
      if (RST || cmd_clear)        div_q <= '0;
      else if (state_q == SW_RUN)  div_q <= tick ? '0 : div_q + 1'b1;
   end

   // Ripple BCD increment; a carry out of the top digit means all-9s wrapped to 0.
   always_comb begin
      count_inc = count_q;
      wrap      = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (wrap) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               wrap                = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || cmd_clear) begin
         count_q <= '0;
         lap_q   <= '0;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (tick) begin
            count_q <= count_inc;
            if (wrap) ovf_q <= 1'b1;
         end
         // Lap samples the pre-increment count and a fresh capture restarts the hold.
         if (cmd_lap) begin
            lap_q  <= count_q;
            hold_q <= HOLD_INIT;
         end else if (tick && (hold_q != 8'd0)) begin
            hold_q <= hold_q - 8'd1;
         end
      end
   end

   assign count_bcd  = count_q;
   assign lap_active = (hold_q != 8'd0);
   assign shown_bcd  = lap_active ? lap_q : count_q;
   assign running    = (state_q == SW_RUN);
   assign overflow   = ovf_q;

   sw_seg_scan #(
      .DIGITS     (DIGITS),
      .SCAN_DIV_W (SCAN_DIV_W)
   ) u_scan (
      .clk   (CLK),
      .rst   (RST),
      .shown (shown_bcd),
      .seg_n (seg_n),
      .dig_n (dig_n)
   );

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core (DIGITS=2, TICK_DIV=4, LAP_HOLD_TICKS=3, SCAN_DIV_W=2).
// Cycle n counts falling edges after reset release; a press takes effect on posedge n+3.
module tb_bcd_stopwatch_core;

   logic       CLK = 1'b0;
   logic       RST;
   logic       btn_start, btn_stop, btn_clear, btn_lap;
   logic [7:0] count_bcd, shown_bcd;
   logic       running, lap_active, overflow;
   logic [6:0] seg_n;
   logic [1:0] dig_n;

   int tests = 0;
   int fails = 0;
   int n     = 0;

   bcd_stopwatch_core #(
      .DIGITS(2), .TICK_DIV(4), .LAP_HOLD_TICKS(3), .SCAN_DIV_W(2)
   ) dut (
      .CLK(CLK), .RST(RST),
      .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
      .count_bcd(count_bcd), .shown_bcd(shown_bcd),
      .running(running), .lap_active(lap_active), .overflow(overflow),
      .seg_n(seg_n), .dig_n(dig_n)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at n=%0d: got %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic adv(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic goto(input int t);
      if (t > n) adv(t - n);
   endtask

   // mask = {lap, clear, stop, start}; held 3 cycles so the command is live on return
   task automatic press(input logic [3:0] mask);
      {btn_lap, btn_clear, btn_stop, btn_start} = mask;
      adv(3);
      {btn_lap, btn_clear, btn_stop, btn_start} = 4'b0000;
   endtask

   localparam logic [6:0] SEG_N_0 = 7'b1000000;
   localparam logic [6:0] SEG_N_7 = 7'b1111000;
`ifdef STOPWATCH_BLANK_LEADING_EN
   localparam logic [6:0] SEG_N_D1 = 7'b1111111;
`else
   localparam logic [6:0] SEG_N_D1 = SEG_N_0;
`endif

   initial begin
      RST = 1'b1;
      {btn_lap, btn_clear, btn_stop, btn_start} = 4'b0000;
      repeat (3) @(negedge CLK);
      chk("rst_count",   count_bcd,  8'h00);
      chk("rst_running", running,    1'b0);
      chk("rst_ovf",     overflow,   1'b0);
      chk("rst_lap",     lap_active, 1'b0);
      chk("rst_seg",     seg_n,      7'h7F);
      chk("rst_dig",     dig_n,      2'b11);
      RST = 1'b0;
      n   = 0;

      // Start effective at edge 4; ticks every 4 cycles thereafter.
      goto(1); press(4'b0001);
      chk("start_running", running,   1'b1);
      chk("start_count",   count_bcd, 8'h00);
      goto(43); chk("cnt_09", count_bcd, 8'h09);
      goto(44); chk("cnt_10", count_bcd, 8'h10);

      // Lap at 0x23 held for exactly 3 ticks.
      goto(95); press(4'b1000);
      chk("lap_cnt",    count_bcd,  8'h23);
      chk("lap_shown",  shown_bcd,  8'h23);
      chk("lap_act",    lap_active, 1'b1);
      goto(107);
      chk("lap_hold_act",   lap_active, 1'b1);
      chk("lap_hold_shown", shown_bcd,  8'h23);
      chk("lap_hold_cnt",   count_bcd,  8'h25);
      goto(108);
      chk("lap_end_act",   lap_active, 1'b0);
      chk("lap_end_shown", shown_bcd,  8'h26);

      // start+stop together in RUN pauses; divider resumes from its frozen phase.
      goto(114); press(4'b0011);
      chk("pause_running", running,   1'b0);
      chk("pause_cnt",     count_bcd, 8'h28);
      goto(137); chk("pause_frozen", count_bcd, 8'h28);
      press(4'b0001);
      chk("resume_running", running, 1'b1);
      goto(142); chk("resume_pre",  count_bcd, 8'h28);
      goto(143); chk("resume_tick", count_bcd, 8'h29);

      // Wrap 99 -> 00 sets sticky overflow and keeps counting.
      goto(426);
      chk("pre_wrap_cnt", count_bcd, 8'h99);
      chk("pre_wrap_ovf", overflow,  1'b0);
      goto(427);
      chk("wrap_cnt", count_bcd, 8'h00);
      chk("wrap_ovf", overflow,  1'b1);
      goto(434);
      chk("ovf_sticky", overflow,  1'b1);
      chk("ovf_cnt",    count_bcd, 8'h01);
      chk("ovf_run",    running,   1'b1);

      // Relap inside the hold recaptures and reloads the hold.
      goto(445); press(4'b1000);
      chk("lap5_shown", shown_bcd, 8'h05);
      goto(450); press(4'b1000);
      chk("lap6_shown", shown_bcd,  8'h06);
      chk("lap6_act",   lap_active, 1'b1);
      goto(462);
      chk("reload_act",   lap_active, 1'b1);
      chk("reload_shown", shown_bcd,  8'h06);
      chk("reload_cnt",   count_bcd,  8'h08);
      goto(463);
      chk("reload_end_act",   lap_active, 1'b0);
      chk("reload_end_shown", shown_bcd,  8'h09);

      // Clear beats a simultaneous lap.
      goto(464); press(4'b1000);
      chk("lap_before_clr", lap_active, 1'b1);
      goto(470); press(4'b1100);
      chk("clr_lap",   lap_active, 1'b0);
      chk("clr_ovf",   overflow,   1'b0);
      chk("clr_cnt",   count_bcd,  8'h00);
      chk("clr_shown", shown_bcd,  8'h00);
      chk("clr_run",   running,    1'b0);

      // Run to 7 and pause, then watch the scan.
      goto(476); press(4'b0001);
      goto(507); press(4'b0010);
      chk("scan_setup_run",   running,   1'b0);
      chk("scan_setup_shown", shown_bcd, 8'h07);
      for (int k = 0; k < 8; k++) begin
         goto(512 + 4*k);
         if (k % 2 == 0) begin
            chk("scan_dig1", dig_n, 2'b01);
            chk("scan_seg1", seg_n, SEG_N_D1);
         end else begin
            chk("scan_dig0", dig_n, 2'b10);
            chk("scan_seg0", seg_n, SEG_N_7);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
